// File: rtl/dev_bridge_pkg.sv
// Shared constants for the CPU-to-timer bridge: timer windows, valid register
// offsets and the bridge FSM state encoding.
package dev_bridge_pkg;

  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;
  localparam logic [31:0] WIN_MASK    = 32'hFFFF_FFF0;

  // Byte offsets inside a 16-byte window that hold a timer register.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Misaligned offsets and offset 0xC fall outside this set, so they decode as errors.
  function automatic logic is_valid_offset(input logic [3:0] off);
    return (off == OFF_CTRL) || (off == OFF_PRESET) || (off == OFF_COUNT);
  endfunction

endpackage

// File: rtl/dev_bridge_if.sv
// CPU bus, timer device bus and interrupt lines of the bridge.
// Handshake: the CPU holds cpu_req with stable addr/we/wdata; the bridge takes it
// only while idle and answers with a single-cycle cpu_ack carrying cpu_rdata/cpu_err.
interface dev_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [29:0] dev_addr;
  logic [31:0] dev_din;
  logic        dev_we0;
  logic        dev_we1;
  logic [31:0] dev_dout0;
  logic [31:0] dev_dout1;
  logic        irq0;
  logic        irq1;
  logic [5:0]  hwint;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_dout0, dev_dout1, irq0, irq1,
    output cpu_ack, cpu_rdata, cpu_err, dev_addr, dev_din, dev_we0, dev_we1, hwint
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_dout0, dev_dout1, irq0, irq1,
    input  cpu_ack, cpu_rdata, cpu_err, dev_addr, dev_din, dev_we0, dev_we1, hwint
  );
endinterface

// File: rtl/dev_bridge_decode.sv
// Combinational address decoder: selects Timer0 or Timer1, or flags an error
// for unmapped, reserved-offset or misaligned addresses.
module dev_bridge_decode
  import dev_bridge_pkg::*;
(
  input  logic [31:0] addr,
  output logic        sel0,
  output logic        sel1,
  output logic        err
);

  logic in_win0;
  logic in_win1;
  logic off_ok;

  assign in_win0 = (addr & WIN_MASK) == TIMER0_BASE;
  assign in_win1 = (addr & WIN_MASK) == TIMER1_BASE;
  assign off_ok  = is_valid_offset(addr[3:0]);

  assign sel0 = in_win0 & off_ok;
  assign sel1 = in_win1 & off_ok;
  assign err  = ~(sel0 | sel1);

endmodule

// File: rtl/dev_bridge.sv
// CPU-to-timer bridge: registers one CPU access, drives it to the selected
// timer for one cycle and returns a single-cycle ack; also registers timer irqs.
module dev_bridge
  import dev_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  dev_bridge_if.slave  bus,
  output state_t       dbg_state
);

  state_t      state;
  state_t      state_nxt;
  logic        accept;

  logic        dec_sel0;
  logic        dec_sel1;
  logic        dec_err;

  logic [29:0] addr_r;
  logic [31:0] din_r;
  logic        we_r;
  logic        sel0_r;
  logic        sel1_r;
  logic        err_r;
  logic [31:0] rdata_r;
  logic [5:0]  hwint_r;

  dev_bridge_decode u_decode (
    .addr (bus.cpu_addr),
    .sel0 (dec_sel0),
    .sel1 (dec_sel1),
    .err  (dec_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          accept    = 1'b1;
          state_nxt = dec_err ? RESP : DRIVE;
        end
      end
      DRIVE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so later input changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      din_r   <= '0;
      we_r    <= 1'b0;
      sel0_r  <= 1'b0;
      sel1_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
    end else if (accept) begin
      addr_r  <= bus.cpu_addr[31:2];
      din_r   <= bus.cpu_wdata;
      we_r    <= bus.cpu_we;
      sel0_r  <= dec_sel0;
      sel1_r  <= dec_sel1;
      err_r   <= dec_err;
      rdata_r <= '0;
    end else if (state == DRIVE && !we_r) begin
      rdata_r <= sel1_r ? bus.dev_dout1 : bus.dev_dout0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hwint_r <= '0;
    end else begin
      hwint_r <= {4'b0000, bus.irq1, bus.irq0};
    end
  end

  // Strobes decode from the state register, so an async reset drops them at once.
  assign bus.dev_addr  = addr_r;
  assign bus.dev_din   = din_r;
  assign bus.dev_we0   = (state == DRIVE) & we_r & sel0_r;
  assign bus.dev_we1   = (state == DRIVE) & we_r & sel1_r;
  assign bus.cpu_ack   = (state == RESP);
  assign bus.cpu_err   = (state == RESP) & err_r;
  assign bus.cpu_rdata = (state == RESP) ? rdata_r : 32'h0;
  assign bus.hwint     = hwint_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dev_bridge.sv
// Directed bench for dev_bridge: vector table of single accesses plus sequences
// for back-to-back requests, reset abort and interrupt registration.
module tb_dev_bridge;
  import dev_bridge_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;

  dev_bridge_if bus ();

  dev_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout0;
    logic [31:0] dout1;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_we0;
    int          exp_we1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_access(input vec_t v);
    int          lat;
    int          n0;
    int          n1;
    logic        got_ack;
    logic        ack_err;
    logic [31:0] ack_rdata;
    logic [29:0] seen_addr;
    logic [31:0] seen_din;
    lat = 0; n0 = 0; n1 = 0; got_ack = 1'b0;
    ack_err = 1'b0; ack_rdata = '0; seen_addr = '0; seen_din = '0;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.dev_dout0 = v.dout0;
    bus.dev_dout1 = v.dout1;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = ~v.we;
    bus.cpu_addr  = 32'h0000_7F14;
    bus.cpu_wdata = ~v.wdata;
    while (!got_ack && lat < 5) begin
      @(negedge clk);
      lat++;
      n0 += int'(bus.dev_we0);
      n1 += int'(bus.dev_we1);
      if (lat == 1) begin
        seen_addr = bus.dev_addr;
        seen_din  = bus.dev_din;
      end
      if (bus.cpu_ack) begin
        got_ack   = 1'b1;
        ack_err   = bus.cpu_err;
        ack_rdata = bus.cpu_rdata;
      end
    end
    check("ack_seen", 32'(got_ack), 32'd1);
    check("ack_latency", 32'(lat), v.exp_err ? 32'd1 : 32'd2);
    check("cpu_err", 32'(ack_err), 32'(v.exp_err));
    check("cpu_rdata", ack_rdata, v.exp_rdata);
    check("we0_cycles", 32'(n0), 32'(v.exp_we0));
    check("we1_cycles", 32'(n1), 32'(v.exp_we1));
    if (!v.exp_err) check("dev_addr", 32'(seen_addr), 32'(v.addr[31:2]));
    if (!v.exp_err && v.we) check("dev_din", seen_din, v.wdata);
    @(negedge clk);
    check("ack_single", 32'(bus.cpu_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] b2b_addr[4];
  logic        b2b_we[4];
  logic [31:0] b2b_rdata[4];
  logic        b2b_we0[4];
  logic        b2b_we1[4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            we    addr          wdata         dout0         dout1         err   rdata        we0 we1
    vecs[0]  = '{1'b1, 32'h0000_7F04, 32'h0000_000F, 32'h0,        32'h0,        1'b0, 32'h0,        1, 0};
    vecs[1]  = '{1'b0, 32'h0000_7F18, 32'h0,         32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 0, 0};
    vecs[2]  = '{1'b1, 32'h0000_7F0C, 32'h1234_0000, 32'h5555_5555, 32'h6666_6666, 1'b1, 32'h0,        0, 0};
    vecs[3]  = '{1'b0, 32'h0000_7F06, 32'h0,         32'h5555_5555, 32'h6666_6666, 1'b1, 32'h0,        0, 0};
    vecs[4]  = '{1'b1, 32'h0000_8000, 32'hFFFF_FFFF, 32'h5555_5555, 32'h6666_6666, 1'b1, 32'h0,        0, 0};
    vecs[5]  = '{1'b0, 32'h0000_7F00, 32'h0,         32'hCAFE_F00D, 32'h0,        1'b0, 32'hCAFE_F00D, 0, 0};
    vecs[6]  = '{1'b1, 32'h0000_7F18, 32'h0000_A5A5, 32'h0,        32'h0,        1'b0, 32'h0,        0, 1};
    vecs[7]  = '{1'b0, 32'h0000_7F1C, 32'h0,         32'h7777_7777, 32'h8888_8888, 1'b1, 32'h0,        0, 0};
    vecs[8]  = '{1'b0, 32'h0000_7F08, 32'h0,         32'h0000_0042, 32'h9999_9999, 1'b0, 32'h0000_0042, 0, 0};
    vecs[9]  = '{1'b0, 32'h0000_7F10, 32'h0,         32'h0000_0002, 32'h0000_0001, 1'b0, 32'h0000_0001, 0, 0};
    vecs[10] = '{1'b1, 32'h0000_7F01, 32'hABCD_0000, 32'h0,        32'h0,        1'b1, 32'h0,        0, 0};
    vecs[11] = '{1'b0, 32'h0000_FF04, 32'h0,         32'h3333_3333, 32'h4444_4444, 1'b1, 32'h0,        0, 0};

    b2b_addr  = '{32'h0000_7F00, 32'h0000_7F14, 32'h0000_7F08, 32'h0000_7F10};
    b2b_we    = '{1'b0, 1'b1, 1'b0, 1'b1};
    b2b_rdata = '{32'h0BAD_0001, 32'h0, 32'h0BAD_0001, 32'h0};
    b2b_we0   = '{1'b0, 1'b0, 1'b0, 1'b0};
    b2b_we1   = '{1'b0, 1'b1, 1'b0, 1'b1};

    // reset state, with irq0 high to show hwint is held clear
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_7F04;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.dev_dout0 = 32'h0;
    bus.dev_dout1 = 32'h0;
    bus.irq0      = 1'b1;
    bus.irq1      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_err", 32'(bus.cpu_err), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_we0", 32'(bus.dev_we0), 32'd0);
    check("rst_we1", 32'(bus.dev_we1), 32'd0);
    check("rst_dev_addr", 32'(bus.dev_addr), 32'd0);
    check("rst_dev_din", bus.dev_din, 32'd0);
    check("rst_hwint", 32'(bus.hwint), 32'd0);
    bus.irq0 = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) run_access(vecs[i]);

    // cpu_req held high: accepts every third cycle, garbage address outside IDLE
    bus.dev_dout0 = 32'h0BAD_0001;
    bus.dev_dout1 = 32'h0BAD_0002;
    for (int c = 0; c <= 12; c++) begin
      int k;
      int ph;
      if (c > 0) @(negedge clk);
      k  = c / 3;
      ph = c % 3;
      if (ph == 1) begin
        check("b2b_dev_addr_drive", 32'(bus.dev_addr), 32'(b2b_addr[k][31:2]));
        check("b2b_we0", 32'(bus.dev_we0), 32'(b2b_we0[k]));
        check("b2b_we1", 32'(bus.dev_we1), 32'(b2b_we1[k]));
        check("b2b_ack_drive", 32'(bus.cpu_ack), 32'd0);
      end else if (ph == 2) begin
        check("b2b_dev_addr_hold", 32'(bus.dev_addr), 32'(b2b_addr[k][31:2]));
        check("b2b_ack", 32'(bus.cpu_ack), 32'd1);
        check("b2b_err", 32'(bus.cpu_err), 32'd0);
        check("b2b_rdata", bus.cpu_rdata, b2b_rdata[k]);
      end else begin
        check("b2b_ack_idle", 32'(bus.cpu_ack), 32'd0);
      end
      if (c == 4) check("irq_hwint_before", 32'(bus.hwint), 32'd0);
      if (c == 5) check("irq1_hwint", 32'(bus.hwint), 32'b000010);
      if (c == 8) check("irq1_hwint_clear", 32'(bus.hwint), 32'd0);
      if (c == 4) bus.irq1 = 1'b1;
      if (c == 7) bus.irq1 = 1'b0;
      if (ph == 0 && k < 4) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = b2b_addr[k];
        bus.cpu_we    = b2b_we[k];
        bus.cpu_wdata = 32'h100 + 32'(k);
      end else if (ph == 0) begin
        bus.cpu_req = 1'b0;
      end else begin
        bus.cpu_addr  = 32'hFFFF_FFF0;
        bus.cpu_we    = 1'b1;
        bus.cpu_wdata = 32'hDEAD_DEAD;
      end
    end

    // reset during DRIVE of a write to Timer1 aborts the access
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0000_7F10;
    bus.cpu_wdata = 32'h0000_0005;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("abort_we1_drive", 32'(bus.dev_we1), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("abort_we1_drop", 32'(bus.dev_we1), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_dev_addr", 32'(bus.dev_addr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(bus.cpu_ack), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_ack_after", 32'(bus.cpu_ack), 32'd0);
    run_access('{1'b0, 32'h0000_7F00, 32'h0, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h1234_5678, 0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dev_bridge.md
DEV_BRIDGE -- requirements
Module: dev_bridge

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state rises on posedge clk.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-003 SHALL have port cpu_req  input  1  CPU access request; sampled only in IDLE.
REQ-004 SHALL have port cpu_we  input  1  1 = write, 0 = read.
REQ-005 SHALL have port cpu_addr  input  32  byte address of the access.
REQ-006 SHALL have port cpu_wdata  input  32  write data.
REQ-007 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-008 SHALL have port cpu_rdata  output  32  read data, valid only while cpu_ack=1.
REQ-009 SHALL have port cpu_err  output  1  unmapped or misaligned access; valid only with cpu_ack.
REQ-010 SHALL have port dev_addr  output  30  word address [31:2] driven to both timers.
REQ-011 SHALL have port dev_din  output  32  write data driven to both timers.
REQ-012 SHALL have ports dev_we0 / dev_we1  output  1 each  write enable, Timer0 / Timer1.
REQ-013 SHALL have ports dev_dout0 / dev_dout1  input  32 each  read data from Timer0 / Timer1.
REQ-014 SHALL have ports irq0 / irq1  input  1 each  interrupt request from Timer0 / Timer1.
REQ-015 SHALL have port hwint  output  6  hardware interrupt vector to CP0.

Function
REQ-016 SHALL map Timer0 to 0x0000_7F00-0x0000_7F0B and Timer1 to 0x0000_7F10-0x0000_7F1B; word offsets 0x0, 0x4, 0x8 are valid.
REQ-017 SHALL treat as error any address outside both windows, offset 0xC within a window, or cpu_addr[1:0] != 0.
REQ-018 SHALL implement FSM states IDLE, DRIVE, RESP.
REQ-019 IDLE: on cpu_req=1, SHALL register addr/we/wdata and decode; mapped -> DRIVE, error -> RESP with err flag set; cpu_req=0 -> stay in IDLE.
REQ-020 DRIVE: SHALL drive the registered dev_addr and dev_din; SHALL assert the selected dev_weN for exactly this one cycle on writes; on reads SHALL capture the selected dev_doutN at the clock edge ending DRIVE; always -> RESP.
REQ-021 RESP: SHALL assert cpu_ack for one cycle; cpu_rdata = captured data for mapped reads, 0 for writes and errors; always -> IDLE.
REQ-022 Latency: a request accepted at edge N SHALL produce cpu_ack during cycle N+2 (mapped) or N+1 (error); the minimum issue interval is 3 cycles (mapped), 2 cycles (error).
REQ-023 SHALL ignore cpu_req and input changes outside IDLE; the registered request SHALL be immune to input changes after acceptance.
REQ-024 SHALL never assert dev_we0 and dev_we1 together, and never assert either for reads or errors.
REQ-025 SHALL register hwint each cycle: hwint[0]=irq0, hwint[1]=irq1, hwint[5:2]=0 (one-cycle delay, independent of the FSM).
REQ-026 dev_addr/dev_din SHALL hold their last registered values outside DRIVE.

Reset
REQ-027 On reset=0, SHALL enter IDLE immediately, with cpu_ack=0, cpu_err=0, cpu_rdata=0, dev_we0=dev_we1=0, dev_addr=0, dev_din=0, hwint=0.
REQ-028 Reset in DRIVE or RESP SHALL abort the access: no ack issued, write enables drop at once; the first request after release SHALL be accepted normally.

Structure
REQ-029 Shared package dev_bridge_pkg SHALL hold TIMER0_BASE, TIMER1_BASE, the window mask, valid-offset constants, and the FSM state encoding.
REQ-030 Address decoding SHALL live in a combinational sub-module dev_bridge_decode (inputs addr; outputs sel0, sel1, err).

Verification
REQ-031 Write 0x0000_000F to 0x7F04 -> dev_addr=30'h1FC1 and dev_we0=1 for exactly one cycle, dev_we1=0, cpu_ack 2 cycles after acceptance, cpu_err=0.
REQ-032 Read 0x7F18 with dev_dout1=0xDEAD_BEEF -> cpu_rdata=0xDEAD_BEEF with cpu_ack, dev_we0=dev_we1=0 throughout.
REQ-033 Accesses to 0x7F0C, 0x7F06, and 0x8000 -> cpu_ack with cpu_err=1 one cycle after acceptance, cpu_rdata=0, no write enable asserted.
REQ-034 cpu_req held high continuously with alternating addresses -> mapped accesses accepted every 3 cycles; cpu_addr changes during DRIVE do not alter dev_addr.
REQ-035 reset=0 asserted during DRIVE of a write to 0x7F10 -> dev_we1 drops immediately, no cpu_ack; after release, a read of 0x7F00 completes normally.
REQ-036 Toggle irq1 high -> hwint=6'b000010 one cycle later, unaffected by concurrent bus activity.
